// File: rtl/axi_sram_slave.sv
// Single-port word-addressed SRAM behind an AXI3-style slave port.
// One transaction at a time; INCR/FIXED bursts, byte-strobed writes, round-robin AR/AW arbitration.
module axi_sram_slave #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_RWAIT = 5'b00010,
        S_R     = 5'b00100,
        S_W     = 5'b01000,
        S_B     = 5'b10000
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    state_t      state, next_state;
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [3:0]  id_r;
    logic [31:0] addr_r;
    logic [31:0] addr_next;
    logic [7:0]  len_r;
    logic [2:0]  size_r;
    logic        fixed_r;
    logic [7:0]  beat;
    logic [3:0]  lat_cnt;
    logic        last_write;
    logic        ar_hs, aw_hs, r_hs, w_hs;
    logic        w_end, w_err;
    logic        unused;

    function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
        return a[ADDR_W+1:2];
    endfunction

    assign ar_hs     = arvalid && arready;
    assign aw_hs     = awvalid && awready;
    assign r_hs      = rvalid && rready;
    assign w_hs      = wvalid && wready;
    assign addr_next = fixed_r ? addr_r : addr_r + (32'd1 << size_r);
    assign w_end     = wlast || (beat == len_r);
    assign w_err     = wlast != (beat == len_r);
    // W data is held off during the AW handshake cycle so the burst address is already captured
    assign wready    = (state == S_W) && !awready;
    assign rresp     = 2'b00;
    assign unused    = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (arvalid && awvalid) next_state = last_write ? S_RWAIT : S_W;
                else if (awvalid)       next_state = S_W;
                else if (arvalid)       next_state = S_RWAIT;
            end
            S_RWAIT: if (!arready && lat_cnt == LAT_LAST) next_state = S_R;
            S_R:     if (r_hs && rlast)                   next_state = S_IDLE;
            S_W:     if (w_hs && w_end)                   next_state = S_B;
            S_B:     if (bready)                          next_state = S_IDLE;
            default:                                      next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready    <= 1'b0;
            awready    <= 1'b0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rdata      <= '0;
            rid        <= '0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= 2'b00;
            beat       <= '0;
            lat_cnt    <= '0;
            last_write <= 1'b0;
        end else begin
            arready <= 1'b0;
            awready <= 1'b0;
            case (state)
                S_IDLE: begin
                    beat    <= '0;
                    lat_cnt <= '0;
                    if (next_state == S_RWAIT) begin
                        arready    <= 1'b1;
                        last_write <= 1'b0;
                    end else if (next_state == S_W) begin
                        awready    <= 1'b1;
                        last_write <= 1'b1;
                    end
                end
                S_RWAIT: begin
                    if (!arready) begin
                        lat_cnt <= lat_cnt + 4'd1;
                        if (lat_cnt == LAT_LAST) begin
                            rvalid <= 1'b1;
                            rdata  <= mem[word_idx(addr_r)];
                            rlast  <= (len_r == 8'd0);
                            rid    <= id_r;
                        end
                    end
                end
                S_R: begin
                    if (r_hs) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                        end else begin
                            // fetch the next beat now so it is presented without a bubble
                            beat  <= beat + 8'd1;
                            rdata <= mem[word_idx(addr_next)];
                            rlast <= ((beat + 8'd1) == len_r);
                        end
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        if (w_end) begin
                            bvalid <= 1'b1;
                            bid    <= id_r;
                            bresp  <= w_err ? 2'b10 : 2'b00;
                        end else begin
                            beat <= beat + 8'd1;
                        end
                    end
                end
                S_B: if (bready) bvalid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Request capture, address stepping and memory writes carry no reset
    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            id_r    <= arid;
            addr_r  <= araddr;
            len_r   <= arlen;
            size_r  <= arsize;
            fixed_r <= (arburst == 2'b00);
        end else if (aw_hs) begin
            id_r    <= awid;
            addr_r  <= awaddr;
            len_r   <= awlen;
            size_r  <= awsize;
            fixed_r <= (awburst == 2'b00);
        end else if (r_hs || w_hs) begin
            addr_r  <= addr_next;
        end
        for (int i = 0; i < 4; i++) begin
            if (w_hs && wstrb[i]) mem[word_idx(addr_r)][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single/INCR/FIXED bursts, strobes, backpressure,
// AR/AW round-robin, early wlast and reset during a read burst.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] wbuf [0:7];
    logic [31:0] rbuf [0:15];
    logic        rlbuf [0:15];
    logic [3:0]  ridv;

    axi_sram_slave #(.ADDR_W(12), .RD_LAT(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'h0), .arprot(3'h0), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(2'b00), .awcache(4'h0), .awprot(3'h0), .awvalid(awvalid), .awready(awready),
        .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] bidv);
        int t;
        resp = 2'bxx;
        bidv = 4'bxxxx;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 20) begin @(negedge aclk); t++; end
        if (!awready) begin
            n_cmp++; n_err++;
            $display("FAIL aw_timeout: awready=%0b required 1", awready);
            awvalid = 1'b0;
            return;
        end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wdata = wbuf[b]; wstrb = strb; wlast = (b == nbeats - 1); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 20) begin @(negedge aclk); t++; end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (!bvalid && t < 20) begin @(negedge aclk); t++; end
        resp = bresp;
        bidv = bid;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int stall_beat, input int stall_n,
                            output int lat, output bit hold_ok, output int nbeats);
        int t, hs, beat;
        logic [31:0] d;
        logic l;
        lat = -1; hold_ok = 1'b1; nbeats = 0;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        rready = 1'b1;
        t = 0;
        while (!arready && t < 20) begin @(negedge aclk); t++; end
        if (!arready) begin
            n_cmp++; n_err++;
            $display("FAIL ar_timeout: arready=%0b required 1", arready);
            arvalid = 1'b0;
            return;
        end
        hs = cyc;
        @(negedge aclk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 40) begin @(negedge aclk); t++; end
        lat = cyc - hs;
        beat = 0; t = 0;
        while (beat <= int'(len) && t < 100) begin
            if (rvalid) begin
                if (beat == stall_beat && stall_n > 0) begin
                    rready = 1'b0;
                    d = rdata; l = rlast;
                    repeat (stall_n) begin
                        @(negedge aclk);
                        if (rvalid !== 1'b1 || rdata !== d || rlast !== l) hold_ok = 1'b0;
                    end
                    rready = 1'b1;
                end
                rbuf[beat] = rdata; rlbuf[beat] = rlast; ridv = rid;
                beat++;
            end
            @(negedge aclk);
            t++;
        end
        nbeats = beat;
    endtask

    task automatic test_reset;
        logic [49:0] obs;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        obs = {arready, awready, wready, rvalid, rlast, bvalid, rresp, bresp, rid, bid, rdata};
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", obs);
        end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_single;
        logic [1:0] resp; logic [3:0] b; int lat, n; bit hold;
        wbuf[0] = 32'hDEADBEEF;
        axi_write(4'h5, 32'h10, 8'd0, 2'b01, 1, 4'hF, resp, b);
        n_cmp++; if (resp !== 2'b00) begin n_err++; $display("FAIL single_bresp: got %b required 00", resp); end
        n_cmp++; if (b !== 4'h5) begin n_err++; $display("FAIL single_bid: got %h required 5", b); end
        axi_read(4'hA, 32'h10, 8'd0, 2'b01, -1, 0, lat, hold, n);
        n_cmp++; if (rbuf[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata: got %h required deadbeef", rbuf[0]); end
        n_cmp++; if (rlbuf[0] !== 1'b1) begin n_err++; $display("FAIL single_rlast: got %b required 1", rlbuf[0]); end
        n_cmp++; if (ridv !== 4'hA) begin n_err++; $display("FAIL single_rid: got %h required a", ridv); end
        n_cmp++; if (n !== 1 || rvalid !== 1'b0) begin n_err++; $display("FAIL single_beats: got %0d beats rvalid=%b required 1 beat rvalid=0", n, rvalid); end
    endtask

    task automatic test_incr;
        logic [1:0] resp; logic [3:0] b; int lat, n; bit hold;
        logic [31:0] exp_d [0:3];
        exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'h33333333; exp_d[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) wbuf[i] = exp_d[i];
        axi_write(4'h3, 32'h100, 8'd3, 2'b01, 4, 4'hF, resp, b);
        n_cmp++; if (resp !== 2'b00) begin n_err++; $display("FAIL incr_bresp: got %b required 00", resp); end
        axi_read(4'h6, 32'h100, 8'd3, 2'b01, -1, 0, lat, hold, n);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL incr_latency: got %0d required 2", lat); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rbuf[i] !== exp_d[i]) begin n_err++; $display("FAIL incr_rdata%0d: got %h required %h", i, rbuf[i], exp_d[i]); end
            n_cmp++;
            if (rlbuf[i] !== (i == 3)) begin n_err++; $display("FAIL incr_rlast%0d: got %b required %b", i, rlbuf[i], (i == 3)); end
        end
    endtask

    task automatic test_strobe;
        logic [1:0] resp; logic [3:0] b; int lat, n; bit hold;
        wbuf[0] = 32'hAABBCCDD;
        axi_write(4'h1, 32'h20, 8'd0, 2'b01, 1, 4'hF, resp, b);
        wbuf[0] = 32'h11223344;
        axi_write(4'h1, 32'h20, 8'd0, 2'b01, 1, 4'b0101, resp, b);
        n_cmp++; if (resp !== 2'b00) begin n_err++; $display("FAIL strobe_bresp: got %b required 00", resp); end
        axi_read(4'h2, 32'h20, 8'd0, 2'b01, -1, 0, lat, hold, n);
        n_cmp++; if (rbuf[0] !== 32'hAA22CC44) begin n_err++; $display("FAIL strobe_rdata: got %h required aa22cc44", rbuf[0]); end
    endtask

    task automatic test_fixed_alias;
        logic [1:0] resp; logic [3:0] b; int lat, n; bit hold;
        wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
        axi_write(4'h4, 32'h300, 8'd1, 2'b00, 2, 4'hF, resp, b);
        axi_read(4'h4, 32'h300, 8'd0, 2'b01, -1, 0, lat, hold, n);
        n_cmp++; if (rbuf[0] !== 32'h5A5A5A5A) begin n_err++; $display("FAIL fixed_write: got %h required 5a5a5a5a", rbuf[0]); end
        axi_read(4'h4, 32'h10, 8'd1, 2'b00, -1, 0, lat, hold, n);
        n_cmp++;
        if (rbuf[0] !== 32'hDEADBEEF || rbuf[1] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL fixed_read: got %h %h required deadbeef deadbeef", rbuf[0], rbuf[1]);
        end
        axi_read(4'h4, 32'h4010, 8'd0, 2'b01, -1, 0, lat, hold, n);
        n_cmp++; if (rbuf[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL alias_read: got %h required deadbeef", rbuf[0]); end
    endtask

    task automatic test_backpressure;
        int lat, n; bit hold;
        logic [31:0] exp_d [0:3];
        exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'h33333333; exp_d[3] = 32'h44444444;
        axi_read(4'h8, 32'h100, 8'd3, 2'b01, 1, 3, lat, hold, n);
        n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %b required 1", hold); end
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL bp_beats: got %0d required 4", n); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rbuf[i] !== exp_d[i] || rlbuf[i] !== (i == 3)) begin
                n_err++; $display("FAIL bp_beat%0d: got %h/%b required %h/%b", i, rbuf[i], rlbuf[i], exp_d[i], (i == 3));
            end
        end
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL bp_end: rvalid got %b required 0", rvalid); end
    endtask

    task automatic test_round_robin;
        logic [2:0] got_w;
        logic [31:0] rd;
        bit held;
        int t;
        got_w = 3'b000;
        @(negedge aclk);
        aresetn = 1'b0;
        awid = 4'h2; awaddr = 32'h200; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2;
        arid = 4'h7; araddr = 32'h200; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2;
        arvalid = 1'b1; awvalid = 1'b1; rready = 1'b1; bready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!(arready || awready) && t < 20) begin @(negedge aclk); t++; end
            if (!(arready || awready)) begin
                n_cmp++; n_err++;
                $display("FAIL rr_timeout%0d: no ready seen required one", k);
                break;
            end
            got_w[k] = awready;
            @(negedge aclk);
            if (got_w[k]) begin
                wdata = 32'h0BADF00D + k; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
                t = 0;
                while (!wready && t < 20) begin @(negedge aclk); t++; end
                @(negedge aclk);
                wvalid = 1'b0; wlast = 1'b0;
                t = 0;
                while (!bvalid && t < 20) begin @(negedge aclk); t++; end
                if (k == 0) begin
                    held = 1'b1;
                    repeat (5) begin @(negedge aclk); if (bvalid !== 1'b1) held = 1'b0; end
                    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL rr_bhold: got %b required 1", held); end
                    n_cmp++; if (bid !== 4'h2) begin n_err++; $display("FAIL rr_bid: got %h required 2", bid); end
                end
                bready = 1'b1;
                @(negedge aclk);
                bready = 1'b0;
            end else begin
                t = 0;
                while (!rvalid && t < 20) begin @(negedge aclk); t++; end
                rd = rdata;
                @(negedge aclk);
                n_cmp++; if (rd !== 32'h0BADF00D) begin n_err++; $display("FAIL rr_rdata: got %h required 0badf00d", rd); end
            end
        end
        arvalid = 1'b0; awvalid = 1'b0;
        n_cmp++; if (got_w !== 3'b101) begin n_err++; $display("FAIL rr_order: got %b required 101", got_w); end
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_early_wlast;
        logic [1:0] resp; logic [3:0] b; int lat, n; bit hold;
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
        axi_write(4'h9, 32'h400, 8'd3, 2'b01, 2, 4'hF, resp, b);
        n_cmp++; if (resp !== 2'b10) begin n_err++; $display("FAIL early_bresp: got %b required 10", resp); end
        n_cmp++; if (b !== 4'h9) begin n_err++; $display("FAIL early_bid: got %h required 9", b); end
        axi_read(4'h9, 32'h400, 8'd1, 2'b01, -1, 0, lat, hold, n);
        n_cmp++;
        if (rbuf[0] !== 32'hCAFE0001 || rbuf[1] !== 32'hCAFE0002) begin
            n_err++; $display("FAIL early_data: got %h %h required cafe0001 cafe0002", rbuf[0], rbuf[1]);
        end
    endtask

    task automatic test_reset_mid_read;
        int t, lat, n; bit quiet, hold;
        arid = 4'h1; araddr = 32'h100; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2;
        arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (!arready && t < 20) begin @(negedge aclk); t++; end
        @(negedge aclk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 20) begin @(negedge aclk); t++; end
        n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL mid_start: rvalid got %b required 1", rvalid); end
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0) begin
            n_err++; $display("FAIL mid_reset: rvalid=%b rlast=%b rdata=%h required 0 0 0", rvalid, rlast, rdata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        n_cmp++; if (dut.state !== 5'b00001) begin n_err++; $display("FAIL mid_state: got %b required 00001", dut.state); end
        quiet = 1'b1;
        repeat (8) begin @(negedge aclk); if (rvalid !== 1'b0 || arready !== 1'b0) quiet = 1'b0; end
        n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL mid_quiet: got %b required 1", quiet); end
        axi_read(4'hC, 32'h10, 8'd0, 2'b01, -1, 0, lat, hold, n);
        n_cmp++; if (rbuf[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL mid_recover: got %h required deadbeef", rbuf[0]); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_incr;
        test_strobe;
        test_fixed_alias;
        test_backpressure;
        test_round_robin;
        test_early_wlast;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
